// File: rtl/rr_arb8.sv
// rr_arb8: 8-way round-robin arbiter with registered one-hot grant,
// optional hold-timeout revoke (compile with RR_ARB8_TIMEOUT_EN).
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  async active-low reset
//   req        in   8  level request vector, bit i = requester i
//   done       in   1  one-cycle release pulse from current owner
//   gnt        out  8  registered one-hot grant
//   gnt_idx    out  3  registered binary index of owner (0 when idle)
//   gnt_valid  out  1  high exactly when gnt is nonzero
//   timeout    out  1  one-cycle pulse on forced revoke (0 unless
//                      RR_ARB8_TIMEOUT_EN is defined)
//
// Parameter HOLD_MAX (1..255): grant cycles allowed per owner before
// the revoke; only meaningful with RR_ARB8_TIMEOUT_EN.

module rr_arb8 #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("rr_arb8: HOLD_MAX must be within 1..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] idx_q, idx_d;
  logic       vld_q, vld_d;

  logic [3:0] pick;
  logic       rel;

  // Rotating priority: first set bit at or above p, wrapping 7->0.
  // Scanning offsets high-to-low lets the lowest offset win.
  function automatic logic [3:0] pick_rr(
    input logic [7:0] r,
    input logic [2:0] p
  );
    logic [3:0] res;
    logic [2:0] k;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      k = p + 3'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  assign pick = pick_rr(req, ptr_q);

  // Dropping the request and pulsing done together is one release.
  assign rel = done | ~req[idx_q];

`ifdef RR_ARB8_TIMEOUT_EN
  localparam logic [7:0] HoldLim = 8'(HOLD_MAX - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d;
  logic       expired;

  // cnt_q counts completed grant cycles; this cycle is the last one
  // allowed once it reaches HOLD_MAX-1.
  assign expired = (cnt_q >= HoldLim);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
`ifdef RR_ARB8_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick[3]) begin
          state_d = GRANT;
          gnt_d   = 8'b0000_0001 << pick[2:0];
          idx_d   = pick[2:0];
          vld_d   = 1'b1;
`ifdef RR_ARB8_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = IDLE;
          gnt_d   = 8'd0;
          idx_d   = 3'd0;
          vld_d   = 1'b0;
          ptr_d   = idx_q + 3'd1;
`ifdef RR_ARB8_TIMEOUT_EN
          cnt_d   = 8'd0;
        end else if (expired) begin
          state_d = IDLE;
          gnt_d   = 8'd0;
          idx_d   = 3'd0;
          vld_d   = 1'b0;
          ptr_d   = idx_q + 3'd1;
          cnt_d   = 8'd0;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'd0;
        idx_d   = 3'd0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      gnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

`ifdef RR_ARB8_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;

endmodule
